decoder_s2: RTL

Second decode stage of the WS2812 receive pipeline, directly downstream of the high-cycle decoder. It commits each bit decoded from the high period, after checking its low period against the timing windows. It shifts committed bits into 24-bit GRB pixels and detects the reset (latch) gap that ends a frame. Completed pixels are presented to the next stage through a valid/ready handshake, and protocol violations are flagged.

---
 rtl/decoder_s2_pkg.sv | 67 ++++++
 rtl/decoder_s2_shift.sv | 43 ++++
 rtl/decoder_s2.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/decoder_s2_pkg.sv
// Shared types and timing constants for the WS2812 second decode stage.
// Window values assume a 20 MHz pipeline clock (50 ns per cycle).
package decoder_s2_pkg;

  localparam int BITS_PER_PIXEL = 24;
  localparam int CNT_W          = 10;

  // pipeline_types
  typedef enum logic [1:0] {
    ERR_HIGH    = 2'd0,
    ERR_LOW     = 2'd1,
    ERR_PARTIAL = 2'd2,
    ERR_OVFL    = 2'd3
  } err_code_e;

  typedef struct packed {
    logic             decode_bit;
    logic             valid;
    logic [CNT_W-1:0] counter;
    logic             rising;
  } decoder_s2_input_t;

  typedef struct packed {
    logic [BITS_PER_PIXEL-1:0] pixel;
    logic                      pixel_valid;
    logic                      frame_end;
    logic                      error;
    err_code_e                 err_code;
  } decoder_s3_input_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESYNC} state_e;

  // timing_constants
  typedef struct packed {
    int unsigned t0l_min;
    int unsigned t0l_max;
    int unsigned t1l_min;
    int unsigned t1l_max;
    int unsigned reset_min;
  } decode_params_t;

  function automatic int unsigned clip(input int unsigned v, input int unsigned cw);
    int unsigned max_v;
    max_v = (cw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
    return (v > max_v) ? max_v : v;
  endfunction

  // Low windows are nominal +/-150 ns; the reset gap is left unclipped so an
  // undersized counter is caught at elaboration rather than silently shortened.
  function automatic decode_params_t init_decode_params(input int unsigned cw);
    decode_params_t p;
    p.t0l_min   = clip(14, cw);
    p.t0l_max   = clip(20, cw);
    p.t1l_min   = clip(6, cw);
    p.t1l_max   = clip(12, cw);
    p.reset_min = 1000;
    return p;
  endfunction

  localparam decode_params_t TIMING = init_decode_params(CNT_W);
  localparam int unsigned T0L_CYCLES_MIN   = TIMING.t0l_min;
  localparam int unsigned T0L_CYCLES_MAX   = TIMING.t0l_max;
  localparam int unsigned T1L_CYCLES_MIN   = TIMING.t1l_min;
  localparam int unsigned T1L_CYCLES_MAX   = TIMING.t1l_max;
  localparam int unsigned RESET_CYCLES_MIN = TIMING.reset_min;

endpackage

// File: rtl/decoder_s2_shift.sv
// Pixel shifter: holds the bits committed so far and the bit index.
// Only W-1 bits are stored; the final bit joins combinationally on the wrap.
module pixel_shift_reg #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic         clear,
  input  logic         bit_in,
  output logic [W-1:0] word_next,
  output logic         last
);
  localparam int IW = $clog2(W);

  logic [W-2:0]  sr_q, sr_d;
  logic [IW-1:0] idx_q, idx_d;

  assign word_next = {sr_q, bit_in};
  assign last      = (idx_q == IW'(W-1));

  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    if (clear) begin
      sr_d  = '0;
      idx_d = '0;
    end else if (shift_en) begin
      sr_d  = word_next[W-2:0];
      idx_d = last ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: rtl/decoder_s2.sv
// WS2812 receive stage 2: commits decoded bits, assembles GRB pixels, detects
// the latch gap. Optional low-period check: define DECODER_S2_LOW_CHECK_EN.
module decoder_s2 import decoder_s2_pkg::*; #(
  parameter int Pbitsperpixel = BITS_PER_PIXEL,
  parameter int Cwidthcounter = CNT_W
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  decoder_s2_input_t i_decoder_s2,
  input  logic              i_ready,
  output decoder_s3_input_t o_decoder_s3
);
  localparam decode_params_t TP = init_decode_params(Cwidthcounter);
  localparam logic [Cwidthcounter-1:0] RST_MIN = Cwidthcounter'(TP.reset_min);
  localparam logic [Cwidthcounter-1:0] T0L_MIN = Cwidthcounter'(TP.t0l_min);
  localparam logic [Cwidthcounter-1:0] T0L_MAX = Cwidthcounter'(TP.t0l_max);
  localparam logic [Cwidthcounter-1:0] T1L_MIN = Cwidthcounter'(TP.t1l_min);
  localparam logic [Cwidthcounter-1:0] T1L_MAX = Cwidthcounter'(TP.t1l_max);
`ifdef DECODER_S2_LOW_CHECK_EN
  localparam bit LOW_CHECK = 1'b1;
`else
  localparam bit LOW_CHECK = 1'b0;
`endif

  if (TP.reset_min > (2**Cwidthcounter) - 1) begin : g_bad_reset
    $error("RESET_CYCLES_MIN does not fit in Cwidthcounter bits");
  end
  if (Cwidthcounter != CNT_W || Pbitsperpixel != BITS_PER_PIXEL) begin : g_bad_width
    $error("parameters disagree with the pipeline struct widths");
  end

  logic [Cwidthcounter-1:0] cnt;
  logic                     rising, is_gap, in_window, low_ok, ovfl;
  state_e                   state_q, state_d;
  logic                     pending_q, pending_d, gap_seen_q, gap_seen_d;
  logic                     shift_en, sr_clear, last, wrap, load, err, fe;
  err_code_e                code;
  logic [Pbitsperpixel-1:0] word_next;
  decoder_s3_input_t        out_q, out_d;

  assign cnt       = i_decoder_s2.counter;
  assign rising    = i_decoder_s2.rising;
  assign is_gap    = (cnt >= RST_MIN) && !gap_seen_q;
  assign in_window = i_decoder_s2.decode_bit ? (cnt >= T1L_MIN && cnt <= T1L_MAX)
                                             : (cnt >= T0L_MIN && cnt <= T0L_MAX);
  assign low_ok    = in_window || !LOW_CHECK;
  assign ovfl      = out_q.pixel_valid && !i_ready;
  assign wrap      = shift_en && last;

  pixel_shift_reg #(.W(Pbitsperpixel)) u_shift (
    .clk      (i_clk),
    .rst_n    (i_reset_n),
    .shift_en (shift_en),
    .clear    (sr_clear),
    .bit_in   (i_decoder_s2.decode_bit),
    .word_next(word_next),
    .last     (last)
  );

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    gap_seen_d = rising ? 1'b0 : ((cnt >= RST_MIN) ? 1'b1 : gap_seen_q);
    shift_en   = 1'b0;
    sr_clear   = 1'b0;
    err        = 1'b0;
    code       = ERR_HIGH;
    fe         = 1'b0;
    case (state_q)
      S_IDLE: if (rising) begin
        pending_d = 1'b1;
        sr_clear  = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: if (is_gap) begin
        // The gap closes the last bit's low period: commit without a window check.
        if (pending_q) begin
          if (!i_decoder_s2.valid) begin
            err = 1'b1; code = ERR_HIGH;
          end else begin
            shift_en = 1'b1;
            if (!last)     begin err = 1'b1; code = ERR_PARTIAL; end
            else if (ovfl) begin err = 1'b1; code = ERR_OVFL;    end
            else           fe = 1'b1;
          end
        end
        // The gap itself is the resync point, so errors here land in IDLE.
        state_d   = S_IDLE;
        pending_d = 1'b0;
        sr_clear  = err;
        if (rising) begin
          state_d   = S_RUN;
          pending_d = 1'b1;
          sr_clear  = 1'b1;
        end
      end else if (rising) begin
        if (!i_decoder_s2.valid) begin
          err = 1'b1; code = ERR_HIGH;
        end else if (!low_ok) begin
          err = 1'b1; code = ERR_LOW;
        end else begin
          shift_en = 1'b1;
          if (last && ovfl) begin err = 1'b1; code = ERR_OVFL; end
        end
        if (err) begin
          sr_clear  = 1'b1;
          pending_d = 1'b0;
          state_d   = S_RESYNC;
        end
      end
      S_RESYNC: if (is_gap) begin
        state_d = S_IDLE;
        if (rising) begin
          state_d   = S_RUN;
          pending_d = 1'b1;
          sr_clear  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign load = wrap && !err;

  always_comb begin
    out_d             = '0;
    out_d.pixel       = load ? word_next : out_q.pixel;
    out_d.pixel_valid = load || (out_q.pixel_valid && !i_ready);
    out_d.frame_end   = fe;
    out_d.error       = err;
    out_d.err_code    = err ? code : ERR_HIGH;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      pending_q  <= 1'b0;
      gap_seen_q <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      gap_seen_q <= gap_seen_d;
      out_q      <= out_d;
    end
  end

  assign o_decoder_s3 = out_q;
endmodule
